count_display: RTL and testbench

COUNT_DISPLAY -- requirements
Module: count_display

---
 rtl/count_display_pkg.sv | 40 ++++
 rtl/count_display_if.sv | 16 +
 rtl/count_display_bin2bcd_iter.sv | 59 +++++
 rtl/count_display.sv | 154 +++++++++++++++
 tb/tb_count_display.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/count_display_pkg.sv
// count_display_pkg: shared types and constants for the count_display slice.
//   state_e     - conversion FSM states (IDLE, CONV, LOAD)
//   SEG_LUT     - active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   SEG_BLANK   - all segments off
//   NUM_DIGITS  - number of anode lines on the display
//   seg_of()    - digit-to-segment lookup, blank for non-decimal nibbles
package count_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n is the pattern for digit n.
  localparam logic [9:0][6:0] SEG_LUT = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    s = SEG_BLANK;
    if (d <= 4'd9) s = SEG_LUT[d];
    return s;
  endfunction

endpackage

// File: rtl/count_display_if.sv
// count_display_if: start/done handshake between the display controller
// (master) and the iterative binary-to-BCD converter (slave).
//   start - one-cycle request, bin is sampled on the same edge
//   bin   - 6-bit binary value to convert
//   done  - high in the cycle whose closing edge performs the final step;
//           bcd is complete from the following cycle on
//   bcd   - {tens[3:0], ones[3:0]}
interface count_display_if;
  logic       start;
  logic [5:0] bin;
  logic       done;
  logic [7:0] bcd;

  modport master (output start, output bin, input  done, input  bcd);
  modport slave  (input  start, input  bin, output done, output bcd);
endinterface

// File: rtl/count_display_bin2bcd_iter.sv
// bin2bcd_iter: double-dabble converter, one shift-add-3 step per cycle,
// six steps for a 6-bit input.
//   clk, rst - clock, synchronous active-high reset (aborts a conversion)
//   bus      - slave side of count_display_if (start/bin in, done/bcd out)
module bin2bcd_iter
  import count_display_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  count_display_if.slave  bus
);

  logic [5:0] sh_q,   sh_d;
  logic [7:0] bcd_q,  bcd_d;
  logic [2:0] iter_q, iter_d;
  logic       run_q,  run_d;
  logic [7:0] adj;

  always_comb begin
    adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) adj[3:0] = bcd_q[3:0] + 4'd3;
    if (bcd_q[7:4] >= 4'd5) adj[7:4] = bcd_q[7:4] + 4'd3;

    sh_d   = sh_q;
    bcd_d  = bcd_q;
    iter_d = iter_q;
    run_d  = run_q;
    if (bus.start) begin
      sh_d   = bus.bin;
      bcd_d  = '0;
      iter_d = 3'd6;
      run_d  = 1'b1;
    end else if (run_q) begin
      {bcd_d, sh_d} = {adj[6:0], sh_q, 1'b0};
      iter_d        = iter_q - 3'd1;
      if (iter_q == 3'd1) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      iter_q <= iter_d;
      run_q  <= run_d;
    end
  end

  // Asserted during the last step so the controller leaves CONV on the
  // same edge that completes the result.
  assign bus.done = run_q && (iter_q == 3'd1);
  assign bus.bcd  = bcd_q;

endmodule

// File: rtl/count_display.sv
// count_display: converts a 6-bit count to two decimal digits and scans
// them onto a 4-digit multiplexed 7-segment display (slot 0 = ones,
// slot 1 = tens, slots 2/3 blank).
//   clk, rst  - clock, synchronous active-high reset
//   cnt_in    - binary value 0..63;  cnt_vld - one-cycle display strobe
//   busy      - conversion in progress (CONV or LOAD)
//   seg       - active-low segments {g,f,e,d,c,b,a}, registered
//   an        - active-low anodes, an[0] rightmost, registered
//   dp        - decimal point, always off (1)
// Optional macro COUNT_DISPLAY_LEADING_ZERO_BLANK_EN: blank slot 1 when
// the tens digit is 0.
module count_display
  import count_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            cnt_in,
  input  logic                  cnt_vld,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);

  state_e     state_q, state_d;
  logic [5:0] pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic       start;
  logic [5:0] start_val;

  count_display_if u_bus ();

  bin2bcd_iter u_conv (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  assign u_bus.start = start;
  assign u_bus.bin   = start_val;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    start      = 1'b0;
    start_val  = cnt_in;
    // Any strobe arriving while busy replaces the pending entry.
    if (state_q != IDLE && cnt_vld) begin
      pend_d     = cnt_in;
      pend_vld_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        // A live strobe beats the pending value, which is then dropped.
        if (cnt_vld || pend_vld_q) begin
          start      = 1'b1;
          start_val  = cnt_vld ? cnt_in : pend_q;
          pend_vld_d = 1'b0;
          state_d    = CONV;
        end
      end
      CONV: if (u_bus.done) state_d = LOAD;
      LOAD: begin
        ones_d  = u_bus.bcd[3:0];
        tens_d  = u_bus.bcd[7:4];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
    end
  end

  assign busy = (state_q != IDLE);

  // Display scan, independent of the conversion FSM.
  logic [RW-1:0]         rcnt_q;
  logic [1:0]            slot_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    unique case (slot_q)
      2'd0: begin
        an_d  = 4'b1110;
        seg_d = seg_of(ones_q);
      end
      2'd1: begin
`ifdef COUNT_DISPLAY_LEADING_ZERO_BLANK_EN
        if (tens_q != 4'd0) begin
          an_d  = 4'b1101;
          seg_d = seg_of(tens_q);
        end
`else
        an_d  = 4'b1101;
        seg_d = seg_of(tens_q);
`endif
      end
      default: begin
        seg_d = SEG_BLANK;
        an_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q <= '0;
      slot_q <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
    end else begin
      if (rcnt_q == RMAX) begin
        rcnt_q <= '0;
        slot_q <= slot_q + 2'd1;
      end else begin
        rcnt_q <= rcnt_q + RW'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_count_display.sv
// tb_count_display: directed, table-driven check of count_display with
// REFRESH_DIV=4, plus hand-written pending-overwrite and reset-abort runs.
module tb_count_display;

`ifdef COUNT_DISPLAY_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  count_display_if stim ();

  always #5 clk = ~clk;

  count_display #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .cnt_in  (stim.bin),
    .cnt_vld (stim.start),
    .busy    (busy),
    .seg     (seg),
    .an      (an),
    .dp      (dp)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [5:0] val;
    logic [6:0] ones;
    logic [6:0] tens;
    bit         tens_zero;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic strobe_and_wait(input logic [5:0] v, output int nbusy);
    @(negedge clk);
    stim.bin   = v;
    stim.start = 1'b1;
    @(negedge clk);
    stim.start = 1'b0;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 50) begin
      nbusy++;
      @(negedge clk);
    end
  endtask

  // Watch one full scan (after a settling cycle) and record what each slot shows.
  task automatic scan(output logic [6:0] o, output logic [6:0] t, output bit tseen, output bit ok);
    o = 'x;
    t = 'x;
    tseen = 1'b0;
    ok = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: o = seg;
        4'b1101: begin t = seg; tseen = 1'b1; end
        4'b1111: if (seg !== 7'b1111111) ok = 1'b0;
        default: ok = 1'b0;
      endcase
      if (dp !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    int bcnt;
    bit saw;
    logic [6:0] o, t;
    bit tseen, ok;

    vecs[0] = '{6'd42, 7'b0100100, 7'b0011001, 1'b0};
    vecs[1] = '{6'd63, 7'b0110000, 7'b0000010, 1'b0};
    vecs[2] = '{6'd0,  7'b1000000, 7'b1000000, 1'b1};
    vecs[3] = '{6'd7,  7'b1111000, 7'b1000000, 1'b1};
    vecs[4] = '{6'd19, 7'b0010000, 7'b1111001, 1'b0};
    vecs[5] = '{6'd58, 7'b0000000, 7'b0010010, 1'b0};
    vecs[6] = '{6'd35, 7'b0010010, 7'b0110000, 1'b0};

    stim.start = 1'b0;
    stim.bin   = '0;
    stim.done  = 1'b0;
    stim.bcd   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_an",   an,   4'b1111);
    chk("reset_seg",  seg,  7'b1111111);
    chk("reset_dp",   dp,   1'b1);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_an",   an,   4'b1110);
    chk("first_seg",  seg,  7'b1000000);
    chk("first_busy", busy, 1'b0);

    for (int i = 0; i < 7; i++) begin
      strobe_and_wait(vecs[i].val, nb);
      chk($sformatf("busy_len_%0d", vecs[i].val), nb, 7);
      scan(o, t, tseen, ok);
      chk($sformatf("ones_%0d", vecs[i].val), o, vecs[i].ones);
      if (vecs[i].tens_zero && LZB) begin
        chk($sformatf("tens_blank_%0d", vecs[i].val), tseen, 1'b0);
      end else begin
        chk($sformatf("tens_lit_%0d", vecs[i].val), tseen, 1'b1);
        chk($sformatf("tens_%0d", vecs[i].val), t, vecs[i].tens);
      end
      chk($sformatf("scan_ok_%0d", vecs[i].val), ok, 1'b1);
    end

    // Strobes 10, 20, 30 back to back: 10 converts, 30 overwrites 20 in pending.
    bcnt = 0;
    saw  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (an === 4'b1101 && seg === 7'b0100100) saw = 1'b1;
      case (c)
        0: begin stim.start = 1'b1; stim.bin = 6'd10; end
        1: stim.bin = 6'd20;
        2: stim.bin = 6'd30;
        3: stim.start = 1'b0;
        default: ;
      endcase
    end
    chk("pend_busy_cycles", bcnt, 14);
    chk("pend_20_shown", saw, 1'b0);
    scan(o, t, tseen, ok);
    chk("pend_ones", o, 7'b1000000);
    chk("pend_tens", t, 7'b0110000);

    // Show 42, then reset during the 3rd CONV cycle of a 55 conversion.
    strobe_and_wait(6'd42, nb);
    @(negedge clk);
    stim.bin   = 6'd55;
    stim.start = 1'b1;
    @(negedge clk);
    stim.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_after", busy, 1'b0);
    saw  = 1'b0;
    bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (an !== 4'b1111 && seg === 7'b0010010) saw = 1'b1;
    end
    chk("abort_busy_idle", bcnt, 0);
    chk("abort_55_shown", saw, 1'b0);
    scan(o, t, tseen, ok);
    chk("abort_ones", o, 7'b1000000);
    if (LZB) begin
      chk("abort_tens_blank", tseen, 1'b0);
    end else begin
      chk("abort_tens", t, 7'b1000000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
